stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Parametrised multi-cycle stage sequencer for the RV32I core. It replaces the fixed 4-state stage counter and the gated `clk_with_stalls` with a clock-enable (`advance`) that all stage registers qualify on. It adds:
- N stages, with the write-back (commit) stage last;
- multiple stall sources;
- a sticky error capture that records its cause and stage;
- a single-step debug mode;
- a retired-instruction counter.

## Interface
Parameters:
- `STAGE_COUNT`, 4: stages per instruction (≥2). Stage `STAGE_COUNT-1` is write-back/commit.
- `INITIAL_DELAY`, 0: warm-up cycles after reset before the first advance.
- `STALL_SOURCES`, 1: number of independent stall request lines.
- `ERROR_SOURCES`, 11: number of error lines (one per opcode class).
- `STALL_TIMEOUT`, 255: stall watchdog limit in cycles (used only with the macro).

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; returns every register to its reset value.
- `stall_request` input STALL_SOURCES: any bit high blocks `advance` in the same cycle.
- `error_in` input ERROR_SOURCES: any bit high while RUN halts the core.
- `step_mode` input 1: 1 = advance only on granted steps.
- `step_request` input 1: one-cycle pulse that grants one full instruction.
- `advance` output 1: combinational clock enable for all stage registers.
- `stage` output SW: current stage index, SW = max(1, $clog2(STAGE_COUNT)).
- `stage_onehot` output STAGE_COUNT: one-hot decode of `stage`.
- `commit` output 1: `advance && stage == STAGE_COUNT-1`; enables PC, rd and register-file writes.
- `retired_count` output 32: number of instructions committed.
- `error` output 1: sticky halt flag.
- `error_cause` output ERROR_SOURCES: `error_in` captured at halt.
- `error_stage` output SW: `stage` captured at halt.
- `error_timeout` output 1: halt was caused by the stall watchdog.

## Operation
State machine: WARMUP, RUN, HALTED.
- **WARMUP**
  - Entered at reset.
  - A counter counts 0..INITIAL_DELAY. Go to RUN on the edge where counter == INITIAL_DELAY. With INITIAL_DELAY=0, WARMUP lasts exactly one cycle.
  - `advance`=0; `error_in` is ignored.
- **RUN**
  - `advance` = !(|stall_request) && !(|error_in) && (!step_mode || step_credit).
  - On `advance`, `stage` increments; it wraps from STAGE_COUNT-1 to 0.
  - On `commit`, `retired_count` increments; it wraps 2^32-1 → 0 silently.
  - If |error_in:
    - `advance` is forced 0 in that same cycle, so the faulting stage never commits.
    - The next state is HALTED, with `error`←1, `error_cause`←error_in, `error_stage`←stage.
  - Error has priority over stall and step.
- **HALTED**
  - Terminal until `reset`.
  - `advance`=0. `stage`, `retired_count` and all error outputs hold.
- **Single step**
  - `step_credit` is internal.
  - A `step_request` seen in RUN with credit=0 sets credit=1. It is ignored if credit is already 1, or in WARMUP/HALTED.
  - Credit clears on the `commit` edge. One grant is therefore one complete pass up to and including write-back, wherever the stage counter was when the grant arrived.
  - Stalls still block `advance` while credit=1.
  - Deasserting `step_mode` mid-instruction resumes free running immediately. Leftover credit clears at the next commit.
- Reset values: state WARMUP, `stage`=0, `stage_onehot`=1, `advance`=0, `commit`=0, `retired_count`=0, `error`=0, `error_cause`=0, `error_stage`=0, `error_timeout`=0, credit=0.
- Reset asserted mid-instruction abandons that instruction: no commit and no count.

## Timing
- `advance` and `commit` are combinational from `stall_request`, `error_in`, `step_mode` and registered state. There are no registered outputs on those paths.
- Throughput: STAGE_COUNT cycles per instruction with no stalls, plus one cycle per stalled cycle.
- First `advance` occurs in cycle INITIAL_DELAY+1 after `reset` deasserts.
- A `step_request` on edge k makes `advance` available from cycle k+1.
- `error` rises one cycle after `error_in`, on the edge that samples it.

## Configuration
- `STAGE_SEQUENCER_STALL_TIMEOUT_EN` defined:
  - A stall counter increments on every RUN cycle where |stall_request blocks `advance`. It clears on `advance`.
  - When the counter reaches STALL_TIMEOUT, the next state is HALTED with `error`=1, `error_timeout`=1 and `error_cause`=0. A same-cycle `error_in` wins and leaves `error_timeout`=0.
- Macro undefined: no stall counter; `error_timeout` tied 0; stalls may last indefinitely.

## Test plan
- Reset, INITIAL_DELAY=3, no stalls → first `advance` in cycle 4; `stage` sequence 0,1,2,3,0; `commit` in each 4th advancing cycle; `retired_count`=5 after 20 advancing cycles.
- `stall_request`=2'b10 held 3 cycles during stage 2 → `advance`=0 for those 3 cycles; `stage` holds at 2; the instruction completes 3 cycles late.
- `error_in`=bit 4 during stage 3 → `commit`=0 that cycle; next cycle `error`=1, `error_cause`=0x010, `error_stage`=3; `retired_count` frozen; later `stall_request`/`step_request` have no effect until `reset`.
- `step_mode`=1, one `step_request` pulse at stage 0 → exactly 4 advances, 1 commit, then idle. A second pulse during the instruction is ignored. A pulse after the commit completes one more instruction.
- Macro defined, STALL_TIMEOUT=8, stall held → halt after the 8th stalled cycle with `error_timeout`=1. Same stimulus with the macro undefined → no halt after 1000 cycles.
- `reset` asserted at stage 2 → all outputs return to reset values asynchronously; `retired_count` unchanged from pre-instruction value only if reset is withheld; after reset it is 0.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: drives the stage-register clock enable, commit strobe, retire count and sticky error capture.
// Optional stall watchdog enabled by defining STAGE_SEQUENCER_STALL_TIMEOUT_EN.
module stage_sequencer #(
   parameter int STAGE_COUNT   = 4,
   parameter int INITIAL_DELAY = 0,
   parameter int STALL_SOURCES = 1,
   parameter int ERROR_SOURCES = 11,
   parameter int STALL_TIMEOUT = 255,
   localparam int SW = (STAGE_COUNT > 2) ? $clog2(STAGE_COUNT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [STALL_SOURCES-1:0] stall_request,
   input  logic [ERROR_SOURCES-1:0] error_in,
   input  logic                     step_mode,
   input  logic                     step_request,
   output logic                     advance,
   output logic [SW-1:0]            stage,
   output logic [STAGE_COUNT-1:0]   stage_onehot,
   output logic                     commit,
   output logic [31:0]              retired_count,
   output logic                     error,
   output logic [ERROR_SOURCES-1:0] error_cause,
   output logic [SW-1:0]            error_stage,
   output logic                     error_timeout
);

   typedef enum logic [1:0] {WARMUP, RUN, HALTED} state_t;

   localparam logic [SW-1:0] LAST_STAGE = SW'(STAGE_COUNT - 1);

   state_t      state, state_next;
   logic [31:0] warm_count;
   logic        step_credit;
   logic        stall_any;
   logic        error_any;
   logic        timeout_hit;

   assign stall_any    = |stall_request;
   assign error_any    = |error_in;
   assign commit       = advance && (stage == LAST_STAGE);
   assign stage_onehot = STAGE_COUNT'(1) << stage;

`ifdef STAGE_SEQUENCER_STALL_TIMEOUT_EN
   logic [31:0] stall_count;
   logic        watchdog_expired;

   assign watchdog_expired = stall_any && !error_any && (stall_count == 32'(STALL_TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count   <= '0;
         error_timeout <= 1'b0;
      end else if (state == RUN) begin
         if (advance)
            stall_count <= '0;
         else if (stall_any && !error_any)
            stall_count <= stall_count + 32'd1;
         if (timeout_hit)
            error_timeout <= 1'b1;
      end
   end
`else
   logic        watchdog_expired;
   wire  [31:0] unused_stall_timeout = STALL_TIMEOUT;

   assign watchdog_expired = 1'b0;
   assign error_timeout    = 1'b0;
`endif

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_next  = state;
      advance     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         WARMUP: begin
            if (warm_count == 32'(INITIAL_DELAY))
               state_next = RUN;
         end
         RUN: begin
            // An error in this cycle suppresses the enable so the faulting stage never commits.
            if (error_any) begin
               state_next = HALTED;
            end else begin
               advance = !stall_any && (!step_mode || step_credit);
               if (watchdog_expired) begin
                  state_next  = HALTED;
                  timeout_hit = 1'b1;
               end
            end
         end
         HALTED: state_next = HALTED;
         default: state_next = WARMUP;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= WARMUP;
         warm_count    <= '0;
         stage         <= '0;
         retired_count <= '0;
         step_credit   <= 1'b0;
         error         <= 1'b0;
         error_cause   <= '0;
         error_stage   <= '0;
      end else begin
         state <= state_next;
         if (state == WARMUP && warm_count != 32'(INITIAL_DELAY))
            warm_count <= warm_count + 32'd1;
         if (advance)
            stage <= (stage == LAST_STAGE) ? '0 : stage + 1'b1;
         if (commit)
            retired_count <= retired_count + 32'd1;
         // Commit closes a granted step; a new grant is only taken while no credit is held.
         if (commit)
            step_credit <= 1'b0;
         else if (state == RUN && step_request && !step_credit)
            step_credit <= 1'b1;
         if ((state == RUN && error_any) || timeout_hit) begin
            error       <= 1'b1;
            error_cause <= error_in;
            error_stage <= stage;
         end
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus random stalls/steps against a cycle model.
module tb_stage_sequencer;

   localparam int SC = 4;
   localparam int ID = 3;
   localparam int SS = 2;
   localparam int ES = 11;
   localparam int ST = 8;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [SS-1:0] stall_request;
   logic [ES-1:0] error_in;
   logic          step_mode;
   logic          step_request;
   logic          advance;
   logic [SW-1:0] stage;
   logic [SC-1:0] stage_onehot;
   logic          commit;
   logic [31:0]   retired_count;
   logic          error;
   logic [ES-1:0] error_cause;
   logic [SW-1:0] error_stage;
   logic          error_timeout;

   stage_sequencer #(
      .STAGE_COUNT(SC), .INITIAL_DELAY(ID), .STALL_SOURCES(SS),
      .ERROR_SOURCES(ES), .STALL_TIMEOUT(ST)
   ) dut (
      .clk(clk), .reset(reset), .stall_request(stall_request), .error_in(error_in),
      .step_mode(step_mode), .step_request(step_request), .advance(advance),
      .stage(stage), .stage_onehot(stage_onehot), .commit(commit),
      .retired_count(retired_count), .error(error), .error_cause(error_cause),
      .error_stage(error_stage), .error_timeout(error_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int dut_adv  = 0;

   // Reference model: plain counters following the sequencing rules.
   typedef enum {M_WARM, M_RUN, M_HALT} mstate_t;
   mstate_t m_state;
   int      m_warm, m_stage, m_stall_run, m_estage, m_cause;
   longint  m_retired;
   bit      m_credit, m_error, m_timeout;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_adv();
      return (m_state == M_RUN) && (stall_request == '0) && (error_in == '0) &&
             (!step_mode || m_credit);
   endfunction

   task automatic model_reset();
      m_state = M_WARM; m_warm = 0; m_stage = 0; m_stall_run = 0;
      m_retired = 0; m_credit = 0; m_error = 0; m_timeout = 0; m_cause = 0; m_estage = 0;
   endtask

   task automatic check_outputs();
      bit a, c;
      a = m_adv();
      c = a && (m_stage == SC - 1);
      check("advance", 32'(advance), 32'(a));
      check("commit", 32'(commit), 32'(c));
      check("stage", 32'(stage), 32'(m_stage));
      check("stage_onehot", 32'(stage_onehot), 32'(1) << m_stage);
      check("retired_count", retired_count, 32'(m_retired));
      check("error", 32'(error), 32'(m_error));
      check("error_cause", 32'(error_cause), 32'(m_cause));
      check("error_stage", 32'(error_stage), 32'(m_estage));
      check("error_timeout", 32'(error_timeout), 32'(m_timeout));
   endtask

   task automatic model_edge(input bit a);
      bit c;
      c = a && (m_stage == SC - 1);
      case (m_state)
         M_WARM: if (m_warm == ID) m_state = M_RUN; else m_warm++;
         M_RUN: begin
            if (c) m_credit = 0;
            else if (step_request && !m_credit) m_credit = 1;
            if (error_in != '0) begin
               m_state = M_HALT; m_error = 1; m_cause = int'(error_in); m_estage = m_stage;
            end else begin
`ifdef STAGE_SEQUENCER_STALL_TIMEOUT_EN
               if (stall_request != '0) begin
                  m_stall_run++;
                  if (m_stall_run == ST) begin
                     m_state = M_HALT; m_error = 1; m_timeout = 1; m_cause = 0; m_estage = m_stage;
                  end
               end
`endif
               if (a) begin
                  m_stage = (m_stage + 1) % SC;
                  m_stall_run = 0;
                  if (c) m_retired++;
               end
            end
         end
         default: ;
      endcase
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cycle(input logic [SS-1:0] st, input logic [ES-1:0] er, input bit sm, input bit sr);
      bit a;
      stall_request = st; error_in = er; step_mode = sm; step_request = sr;
      #1;
      check_outputs();
      if (advance) dut_adv++;
      a = m_adv();
      @(posedge clk);
      model_edge(a);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall_request = '0; error_in = '0; step_mode = 1'b0; step_request = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] frozen;
      bit          sm;
      reset = 1'b1;
      stall_request = '0; error_in = '0; step_mode = 1'b0; step_request = 1'b0;
      @(negedge clk);
      do_reset();

      // Warm-up then 20 free-running cycles: five instructions.
      for (int i = 0; i < ID + 1; i++) cycle('0, '0, 0, 0);
      for (int i = 0; i < 20; i++) cycle('0, '0, 0, 0);
      check("retired_after_20", retired_count, 32'd5);

      // Stall held three cycles in stage 2.
      cycle('0, '0, 0, 0);
      cycle('0, '0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(2'b10, '0, 0, 0);
      check("stage_held_in_stall", 32'(stage), 32'd2);
      cycle('0, '0, 0, 0);
      cycle('0, '0, 0, 0);
      check("retired_after_stall", retired_count, 32'd6);

      // Single step: one grant, a duplicate ignored, then a second grant.
      dut_adv = 0;
      cycle('0, '0, 1, 1);
      for (int i = 0; i < 8; i++) cycle('0, '0, 1, i == 1);
      check("step_advances", 32'(dut_adv), 32'd4);
      check("retired_after_step", retired_count, 32'd7);
      cycle('0, '0, 1, 1);
      for (int i = 0; i < 6; i++) cycle('0, '0, 1, 0);
      check("retired_after_step2", retired_count, 32'd8);

      // Random stalls, mode changes and step pulses.
      sm = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) sm = ~sm;
         cycle(($urandom_range(0, 4) == 0) ? SS'($urandom_range(1, 3)) : '0, '0, sm,
               $urandom_range(0, 5) == 0);
      end

      // Error in the commit stage.
      for (int i = 0; i < 8 && m_stage != SC - 1; i++) cycle('0, '0, 0, 0);
      check("reached_stage3", 32'(stage), 32'd3);
      cycle('0, 11'h010, 0, 0);
      check("halt_error", 32'(error), 32'd1);
      check("halt_cause", 32'(error_cause), 32'h010);
      check("halt_stage", 32'(error_stage), 32'd3);
      frozen = retired_count;
      for (int i = 0; i < 20; i++)
         cycle(SS'($urandom_range(0, 3)), '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("retired_frozen", retired_count, frozen);

      // Asynchronous reset abandoning an instruction at stage 2.
      do_reset();
      for (int i = 0; i < ID + 1 + 2; i++) cycle('0, '0, 0, 0);
      check("mid_instr_stage", 32'(stage), 32'd2);
      do_reset();
      check("retired_after_reset", retired_count, 32'd0);

      // Stall held for a long time: watchdog halt only when enabled.
      for (int i = 0; i < ID + 1; i++) cycle('0, '0, 0, 0);
      for (int i = 0; i < 1000; i++) cycle(2'b01, '0, 0, 0);
`ifdef STAGE_SEQUENCER_STALL_TIMEOUT_EN
      check("watchdog_error", 32'(error), 32'd1);
      check("watchdog_timeout", 32'(error_timeout), 32'd1);
      check("watchdog_cause", 32'(error_cause), 32'd0);
`else
      check("no_watchdog_error", 32'(error), 32'd0);
      check("no_watchdog_timeout", 32'(error_timeout), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
